// File: rtl/rv32_instr_mem.sv
// rtl/rv32_instr_mem.sv - RV32 instruction memory with one outstanding fetch and a program-load write port
// Fetch latency is WAIT_CYCLES+1 cycles; the read word is registered on the edge that enters RESP.
module rv32_instr_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        ready_en;
  logic [31:0] addr_q, cap_addr;
  logic        accept, capture;
  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // ready_en keeps req_ready low during reset and until the first edge after release
  assign req_ready  = ready_en && ((state == IDLE) || ((state == RESP) && resp_ready));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    cap_addr  = addr_q;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cap_addr = req_addr;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(WAIT_CYCLES);
          end
        end else if ((state == RESP) && resp_ready) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          cnt_nxt   = 3'd0;
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      ready_en   <= 1'b0;
      addr_q     <= 32'h0;
      resp_instr <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (accept)
        addr_q <= req_addr;
      if (capture) begin
        if (addr_bad(cap_addr)) begin
          resp_instr <= NOP;
          resp_err   <= 1'b1;
        end else begin
          resp_instr <= mem[cap_addr[AW+1:2]];
          resp_err   <= 1'b0;
        end
      end
    end
  end

  // Storage survives reset; a load on the capture edge is seen by the next fetch only
  always_ff @(posedge clk) begin
    if (load_en && !addr_bad(load_addr))
      mem[load_addr[AW+1:2]] <= load_data;
  end

endmodule

// File: tb/tb_rv32_instr_mem.sv
// tb/tb_rv32_instr_mem.sv - directed self-checking bench for rv32_instr_mem (WAIT_CYCLES 2, 0 and 3)
module tb_rv32_instr_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
  logic [31:0] req_addr [3];
  logic [31:0] resp_instr [3];
  logic [31:0] load_addr [3];
  logic [31:0] load_data [3];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv32_instr_mem #(
      .DEPTH_WORDS(16),
      .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_instr (resp_instr[g]),
      .resp_err   (resp_err[g]),
      .load_en    (load_en[g]),
      .load_addr  (load_addr[g]),
      .load_data  (load_data[g])
    );
  end

  task automatic load_word(input int i, input logic [31:0] a, input logic [31:0] d);
    load_en[i] = 1'b1;
    load_addr[i] = a;
    load_data[i] = d;
    @(posedge clk); #1;
    load_en[i] = 1'b0;
  endtask

  // Issues one fetch from IDLE, returns the response and the edge count from accept to resp_valid
  task automatic fetch(input int i, input logic [31:0] a, output logic [31:0] instr,
                       output logic err, output int cycles);
    cycles = 0;
    req_valid[i] = 1'b1;
    req_addr[i] = a;
    resp_ready[i] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) req_valid[i] = 1'b0;
      if (resp_valid[i]) break;
    end
    instr = resp_instr[i];
    err = resp_err[i];
    resp_ready[i] = 1'b1;
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
    n_checks++;
    if (resp_valid !== 3'b000 || resp_err !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid_err: got valid %b err %b expected 000/000", resp_valid, resp_err);
    end
    n_checks++;
    if (resp_instr[0] !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", resp_instr[0]); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL release_before_edge: got %b expected 000", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 3'b111) begin n_fail++; $display("FAIL first_edge_ready: got %b expected 111", req_ready); end
  endtask

  task automatic test_basic_fetch;
    logic [31:0] instr; logic err; int cyc;
    load_word(0, 32'h0, 32'h0050_0093);
    load_word(0, 32'h4, 32'h00A0_0113);
    fetch(0, 32'h0, instr, err, cyc);
    n_checks++;
    if (cyc !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", cyc); end
    n_checks++;
    if (instr !== 32'h0050_0093 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_word: got %h err %b expected 00500093 err 0", instr, err);
    end
    fetch(0, 32'h4, instr, err, cyc);
    n_checks++;
    if (instr !== 32'h00A0_0113 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_word4: got %h err %b expected 00a00113 err 0", instr, err);
    end
  endtask

  task automatic test_error;
    logic [31:0] instr; logic err; int cyc;
    fetch(0, 32'h2, instr, err, cyc);
    n_checks++;
    if (instr !== 32'h0000_0013 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_misaligned: got %h err %b expected 00000013 err 1", instr, err);
    end
    fetch(0, 32'h40, instr, err, cyc);
    n_checks++;
    if (instr !== 32'h0000_0013 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_range: got %h err %b expected 00000013 err 1", instr, err);
    end
    load_word(0, 32'h3C, 32'h0000_006F);
    fetch(0, 32'h3C, instr, err, cyc);
    n_checks++;
    if (instr !== 32'h0000_006F || err !== 1'b0) begin
      n_fail++; $display("FAIL last_word: got %h err %b expected 0000006f err 0", instr, err);
    end
  endtask

  task automatic test_stall;
    int n = 0;
    req_valid[0] = 1'b1;
    req_addr[0] = 32'h4;
    resp_ready[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      req_addr[0] = 32'h8;
      if (resp_valid[0]) break;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (resp_valid[0] !== 1'b1 || resp_instr[0] !== 32'h00A0_0113 || resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got valid %b instr %h err %b ready %b expected 1 00a00113 0 0",
                 k, resp_valid[0], resp_instr[0], resp_err[0], req_ready[0]);
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    n_checks++;
    if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL stall_release: got valid %b expected 0", resp_valid[0]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hAAAA_0001; exp_w[1] = 32'hAAAA_0002; exp_w[2] = 32'hAAAA_0003;
    for (int k = 0; k < 3; k++) load_word(1, 32'(4 * k), exp_w[k]);
    resp_ready[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid[1] !== 1'b1 || resp_instr[1] !== exp_w[k] || req_ready[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d: got valid %b instr %h ready %b expected 1 %h 1",
                 k, resp_valid[1], resp_instr[1], req_ready[1], exp_w[k]);
      end
      if (k == 2) req_valid[1] = 1'b0;
      else req_addr[1] = 32'(4 * (k + 1));
    end
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    n_checks++;
    if (resp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got valid %b expected 0", resp_valid[1]); end
  endtask

  task automatic test_load_rules;
    logic [31:0] instr; logic err; int cyc;
    load_word(1, 32'h40, 32'hDEAD_BEEF);
    load_word(1, 32'h5, 32'hBADB_AD00);
    fetch(1, 32'h0, instr, err, cyc);
    n_checks++;
    if (instr !== 32'hAAAA_0001) begin n_fail++; $display("FAIL load_range_ignored: got %h expected aaaa0001", instr); end
    fetch(1, 32'h4, instr, err, cyc);
    n_checks++;
    if (instr !== 32'hAAAA_0002) begin n_fail++; $display("FAIL load_misaligned_ignored: got %h expected aaaa0002", instr); end
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h8;
    load_en[1] = 1'b1;
    load_addr[1] = 32'h8;
    load_data[1] = 32'h5555_0008;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    load_en[1] = 1'b0;
    n_checks++;
    if (resp_valid[1] !== 1'b1 || resp_instr[1] !== 32'hAAAA_0003) begin
      n_fail++; $display("FAIL same_edge_old: got valid %b instr %h expected 1 aaaa0003", resp_valid[1], resp_instr[1]);
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    fetch(1, 32'h8, instr, err, cyc);
    n_checks++;
    if (instr !== 32'h5555_0008) begin n_fail++; $display("FAIL same_edge_written: got %h expected 55550008", instr); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] instr; logic err; int cyc;
    req_valid[0] = 1'b1;
    req_addr[0] = 32'h0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got valid %b ready %b expected 0 0", resp_valid[0], req_ready[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_resp%0d: got valid %b expected 0", k, resp_valid[0]); end
    end
    fetch(0, 32'h0, instr, err, cyc);
    n_checks++;
    if (instr !== 32'h0050_0093 || err !== 1'b0 || cyc !== 3) begin
      n_fail++; $display("FAIL after_reset_fetch: got %h err %b lat %0d expected 00500093 0 3", instr, err, cyc);
    end
  endtask

  task automatic test_load_forward;
    int n = 0;
    load_word(2, 32'hC, 32'h1111_1111);
    req_valid[2] = 1'b1;
    req_addr[2] = 32'hC;
    resp_ready[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        req_valid[2] = 1'b0;
        load_en[2] = 1'b1;
        load_addr[2] = 32'hC;
        load_data[2] = 32'h2222_2222;
      end else begin
        load_en[2] = 1'b0;
      end
      if (resp_valid[2]) break;
    end
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL fwd_latency: got %0d expected 4", n); end
    n_checks++;
    if (resp_instr[2] !== 32'h2222_2222 || resp_err[2] !== 1'b0) begin
      n_fail++; $display("FAIL fwd_new_word: got %h err %b expected 22222222 0", resp_instr[2], resp_err[2]);
    end
    resp_ready[2] = 1'b1;
    @(posedge clk); #1;
    resp_ready[2] = 1'b0;
  endtask

  initial begin
    req_valid = '0; resp_ready = '0; load_en = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0; load_addr[i] = '0; load_data[i] = '0;
    end
    test_reset;
    test_basic_fetch;
    test_error;
    test_stall;
    test_back_to_back;
    test_load_rules;
    test_reset_mid;
    test_load_forward;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
